// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, one outstanding memory read,
// small instruction FIFO toward decode, flush and redirect on jump.
module fetch_stage #(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              jump_en,
  input  logic [31:0]       jump_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_pc_n;
  logic [31:0]       pc_inc;
  logic [ADDR_W-1:0] addr_n;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_n;
  logic [31:0]       fifo_instr [DEPTH];
  logic [31:0]       fifo_pc    [DEPTH];
  logic              push;
  logic              pop;
  logic [31:0]       head_instr_n;
  logic [31:0]       head_pc_n;

  assign pop     = instr_valid & instr_ready & ~jump_en;
  assign push    = (state == WAIT) & mem_ack & ~jump_en;
  assign mem_req = (state != IDLE);
  assign pc_inc  = fetch_pc + 32'd1;

  always_comb begin
    count_n = count;
    if (jump_en)
      count_n = '0;
    else if (push & ~pop)
      count_n = count + CW'(1);
    else if (pop & ~push)
      count_n = count - CW'(1);
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = mem_addr;
    unique case (state)
      IDLE: begin
        if (jump_en) begin
          fetch_pc_n = jump_target;
        end else if (count < FULL) begin
          state_n = WAIT;
          addr_n  = fetch_pc[ADDR_W-1:0];
        end
      end
      WAIT: begin
        if (jump_en) begin
          fetch_pc_n = jump_target;
          state_n    = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          fetch_pc_n = pc_inc;
          if (count_n < FULL)
            addr_n = pc_inc[ADDR_W-1:0];
          else
            state_n = IDLE;
        end
      end
      DISCARD: begin
        // memory port has no abort: hold the old address until it acks
        if (jump_en)
          fetch_pc_n = jump_target;
        if (mem_ack)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_n = rd_ptr;
    if (pop)
      rd_ptr_n = rd_ptr + PW'(1);
    head_instr_n = '0;
    head_pc_n    = '0;
    if (count_n != '0) begin
      // nothing left behind the popped head: the fresh word bypasses
      if (count == CW'(pop)) begin
        head_instr_n = mem_rdata;
        head_pc_n    = fetch_pc;
      end else begin
        head_instr_n = fifo_instr[rd_ptr_n];
        head_pc_n    = fifo_pc[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      mem_addr    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      mem_addr    <= addr_n;
      count       <= count_n;
      instr_valid <= (count_n != '0);
      instr_out   <= head_instr_n;
      instr_pc    <= head_pc_n;
      if (jump_en) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        rd_ptr <= rd_ptr_n;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a queue of expected
// {pc, word} pairs per fetch stream is compared against every decode handshake.
module tb_fetch_stage;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clock       = 1'b0;
  logic          reset       = 1'b1;
  logic          jump_en     = 1'b0;
  logic [31:0]   jump_target = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;

  always #5 clock = ~clock;

  fetch_stage #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clock       (clock),
    .reset       (reset),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
  );

  // memory: ack once the request has been held for lat edges
  logic [31:0] mem [1024];
  int   lat       = 1;
  int   w         = 1;
  logic stall     = 1'b0;
  logic extra_ack = 1'b0;
  int   nack      = 0;
  int   cyc       = 0;

  assign mem_ack   = (mem_req && w == 0 && !stall) || extra_ack;
  assign mem_rdata = extra_ack ? 32'hBADBAD00 : mem[mem_addr];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_req && mem_ack)
      nack <= nack + 1;
    if (!mem_req)
      w <= lat;
    else if (mem_ack)
      w <= lat - 1;
    else if (w > 0)
      w <= w - 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void tmo(string name);
    n_chk++;
    $display("FAIL %s: got timeout expected event", name);
  endfunction

  // reference: a stream from pc P yields P, P+1, ... with mem[pc mod 1024]
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] nxt;

  function automatic void refill();
    exp_t e;
    while (expq.size() < 16) begin
      e.pc   = nxt;
      e.word = mem[nxt[9:0]];
      expq.push_back(e);
      nxt = nxt + 32'd1;
    end
  endfunction

  function automatic void restart(logic [31:0] t);
    expq.delete();
    nxt = t;
    refill();
  endfunction

  int            phase   = 0;
  int            nhs     = 0;
  int            hs_cyc[$];
  logic          p_req   = 1'b0;
  logic          p_ack   = 1'b0;
  logic          p_rst   = 1'b1;
  logic [AW-1:0] p_addr  = '0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset && instr_valid && instr_ready && !jump_en) begin
      if (expq.size() == 0) begin
        tmo("scoreboard_empty");
      end else begin
        e = expq.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_out", instr_out, e.word);
        refill();
      end
      nhs++;
      if (phase == 1)
        hs_cyc.push_back(cyc);
    end
    if (!reset && p_req && !p_ack && !p_rst) begin
      chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
      chk("mem_addr_hold", {22'd0, mem_addr}, {22'd0, p_addr});
    end
    p_req  = mem_req;
    p_ack  = mem_ack;
    p_rst  = reset;
    p_addr = mem_addr;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_for(input int kind, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      unique case (kind)
        0: ok = mem_req && !mem_ack;
        1: ok = mem_ack && instr_valid;
        2: ok = mem_req;
        default: ok = mem_ack;
      endcase
      if (!ok)
        step();
    end
    if (!ok)
      tmo(name);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    jump_en = 1'b0;
    step();
    reset = 1'b0;
    restart(32'd0);
  endtask

  task automatic jump(input logic [31:0] t);
    jump_en     = 1'b1;
    jump_target = t;
    restart(t);
    step();
    jump_en = 1'b0;
  endtask

  int            n0;
  logic [AW-1:0] old;

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = $urandom;
    restart(32'd0);

    // reset values and first fetch latency
    step();
    step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    restart(32'd0);
    reset = 1'b0;
    phase = 1;
    step();
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("first_addr", {22'd0, mem_addr}, 32'd0);
    step();
    step();
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_pc", instr_pc, 32'd0);
    repeat (8) step();
    phase = 0;
    if (hs_cyc.size() < 6) begin
      tmo("no_bubble_count");
    end else begin
      for (int i = 1; i < 6; i++)
        chk("no_bubble", hs_cyc[i], hs_cyc[0] + i);
    end

    // backpressure fills the FIFO and stops fetch
    instr_ready = 1'b0;
    do_reset();
    n0 = nack;
    repeat (10) step();
    chk("full_acks", nack - n0, 32'd4);
    chk("full_req_low", {31'd0, mem_req}, 32'd0);
    chk("full_head", instr_out, mem[0]);
    instr_ready = 1'b1;
    wait_for(2, "resume_req");
    chk("resume_addr", {22'd0, mem_addr}, 32'd4);
    repeat (10) step();

    // jump while a slow request is outstanding
    lat = 3;
    do_reset();
    repeat (12) step();
    wait_for(0, "wait_state");
    old = mem_addr;
    n0  = nhs;
    jump(32'h20);
    chk("discard_req", {31'd0, mem_req}, 32'd1);
    chk("discard_addr", {22'd0, mem_addr}, {22'd0, old});
    chk("discard_flush", {31'd0, instr_valid}, 32'd0);
    repeat (30) step();
    chk("after_jump_progress", {31'd0, nhs > n0}, 32'd1);

    // jump coincident with ack and pop
    lat = 1;
    repeat (6) step();
    wait_for(1, "ack_and_valid");
    jump(32'h155);
    chk("coinc_flush", {31'd0, instr_valid}, 32'd0);
    chk("coinc_idle", {31'd0, mem_req}, 32'd0);
    step();
    chk("coinc_req", {31'd0, mem_req}, 32'd1);
    chk("coinc_addr", {22'd0, mem_addr}, 32'h155);
    repeat (6) step();

    // pc and address wrap
    wait_for(1, "ack_and_valid2");
    jump(32'hFFFFFFFF);
    step();
    chk("wrap_addr_hi", {22'd0, mem_addr}, 32'd1023);
    wait_for(3, "wrap_ack");
    step();
    chk("wrap_req", {31'd0, mem_req}, 32'd1);
    chk("wrap_addr_lo", {22'd0, mem_addr}, 32'd0);
    repeat (10) step();

    // reset mid-request followed by a late ack
    lat = 3;
    repeat (4) step();
    wait_for(0, "wait_state2");
    reset = 1'b1;
    step();
    reset     = 1'b0;
    extra_ack = 1'b1;
    restart(32'd0);
    chk("late_req_low", {31'd0, mem_req}, 32'd0);
    step();
    extra_ack = 1'b0;
    chk("late_ignored", {31'd0, instr_valid}, 32'd0);
    chk("late_req", {31'd0, mem_req}, 32'd1);
    chk("late_addr", {22'd0, mem_addr}, 32'd0);
    repeat (20) step();

    // randomized traffic
    n0 = nhs;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0)
        lat = $urandom_range(1, 3);
      instr_ready = ($urandom % 4) != 0;
      stall       = ($urandom % 5) == 0;
      if ($urandom % 400 == 0) begin
        do_reset();
      end else if ($urandom % 40 == 0) begin
        if ($urandom % 2 == 0)
          jump($urandom);
        else
          jump(32'hFFFFFFFF - $urandom_range(0, 3));
      end else begin
        step();
      end
    end
    stall = 1'b0;
    chk("random_progress", {31'd0, (nhs - n0) > 500}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
